// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op codes, FSM states and counter sizing for mult_div_unit
package mdu_pkg;

  // Operation codes presented on the op port
  localparam logic [2:0] MDU_NOP   = 3'b000;
  localparam logic [2:0] MDU_MULT  = 3'b001;
  localparam logic [2:0] MDU_MULTU = 3'b010;
  localparam logic [2:0] MDU_DIV   = 3'b011;
  localparam logic [2:0] MDU_DIVU  = 3'b100;
  localparam logic [2:0] MDU_MTHI  = 3'b101;
  localparam logic [2:0] MDU_MTLO  = 3'b110;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } mdu_state_t;

  // Iteration counter must hold 0..width-1
  function automatic int mdu_cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = mdu_cnt_w(MDU_WIDTH);

endpackage

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - restoring divider step with quotient/remainder registers
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] dsor;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] diff;

  // Partial remainder shifted left by one with the next dividend bit pulled in;
  // the remainder stays below the divisor, so a successful subtract fits WIDTH bits
  always_comb begin
    shifted = {remainder, quotient[WIDTH-1]};
    fits    = (shifted >= {1'b0, dsor});
    diff    = shifted[WIDTH-1:0] - dsor;
  end

  // Load magnitudes on accept, then one restoring step per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient  <= '0;
      remainder <= '0;
      dsor      <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      dsor      <= divisor;
    end else if (step) begin
      remainder <= fits ? diff : shifted[WIDTH-1:0];
      quotient  <= {quotient[WIDTH-2:0], fits};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU with HI/LO; divider enabled by MDU_DIV_EN
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = mdu_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_t         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic               neg_res;

  logic               accept;
  logic               is_mul;
  logic               is_long;
  logic               signed_op;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

`ifdef MDU_DIV_EN
  logic               is_div;
  logic               div_op;
  logic               neg_rem;
  logic               div_zero;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;

  mdu_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clk      (clk),
    .reset    (reset),
    .load     (accept & is_div),
    .step     (state == DIV),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quotient (quotient),
    .remainder(remainder)
  );
`endif

  // Request decode, operand magnitudes and the hold-the-core stall
  always_comb begin
    accept    = start & ~busy;
    is_mul    = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_DIV_EN
    is_div    = (op == MDU_DIV) || (op == MDU_DIVU);
    is_long   = is_mul | is_div;
    signed_op = (op == MDU_MULT) || (op == MDU_DIV);
`else
    is_long   = is_mul;
    signed_op = (op == MDU_MULT);
`endif
    sign_a    = signed_op & rs_data[WIDTH-1];
    sign_b    = signed_op & rt_data[WIDTH-1];
    mag_a     = sign_a ? -rs_data : rs_data;
    mag_b     = sign_b ? -rt_data : rt_data;
    stall     = busy | (start & is_long);
  end

  // Shift-add step: add multiplicand into the upper half when the multiplier LSB is set
  always_comb begin
    mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  end

  // Sign-corrected results presented to HI/LO in FIX
  always_comb begin
    prod_fix = neg_res ? -prod : prod;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
`ifdef MDU_DIV_EN
    if (div_op) begin
      fix_hi = neg_rem ? -remainder : remainder;
      fix_lo = div_zero ? '1 : (neg_res ? -quotient : quotient);
    end
`endif
  end

  // Sequencer, multiply datapath and HI/LO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      prod    <= '0;
      neg_res <= 1'b0;
`ifdef MDU_DIV_EN
      div_op   <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= '0;
            mcand   <= mag_a;
            prod    <= {{WIDTH{1'b0}}, mag_b};
            neg_res <= sign_a ^ sign_b;
`ifdef MDU_DIV_EN
            div_op   <= is_div;
            neg_rem  <= sign_a;
            div_zero <= (rt_data == '0);
`endif
            if (is_mul) begin
              state <= MUL;
              busy  <= 1'b1;
`ifdef MDU_DIV_EN
            end else if (is_div) begin
              state <= DIV;
              busy  <= 1'b1;
`endif
            end else if (op == MDU_MTHI) begin
              hi <= rs_data;
            end else if (op == MDU_MTLO) begin
              lo <= rs_data;
            end
          end
        end
        MUL: begin
          prod <= {mul_sum, prod[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
`ifdef MDU_DIV_EN
        DIV: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
`endif
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_pass;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request; report edges to done and how many samples saw busy
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_n);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NOP;
    lat = 0;
    busy_n = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_n++;
    end
  endtask

  // Single-cycle register write through MTHI/MTLO
  task automatic move_to(input logic [2:0] o, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NOP;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = OP_NOP; rs_data = '0; rt_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({hi, lo, busy, done, stall} !== 67'd0) $display("FAIL reset_state got hi=%h lo=%h busy=%b done=%b stall=%b want all zero", hi, lo, busy, done, stall);
    else n_pass++;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_mult;
    int lat, bn;
    @(negedge clk);
    start = 1'b1; op = OP_MULT; rs_data = 32'hFFFFFFFD; rt_data = 32'h5;
    #1;
    n_checks++;
    if (stall !== 1'b1) $display("FAIL mult_req_stall got %b want 1", stall);
    else n_pass++;
    start = 1'b0; op = OP_NOP;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'h00000005, lat, bn);
    n_checks++;
    if (lat !== 33) $display("FAIL mult_latency got %0d want 33", lat);
    else n_pass++;
    n_checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) $display("FAIL mult_neg got hi=%h lo=%h want FFFFFFFF FFFFFFF1", hi, lo);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL mult_done_pulse got done=%b busy=%b want 0 0", done, busy);
    else n_pass++;
    run_op(OP_MULT, 32'h80000000, 32'h80000000, lat, bn);
    n_checks++;
    if (hi !== 32'h40000000 || lo !== 32'h0) $display("FAIL mult_minneg got hi=%h lo=%h want 40000000 00000000", hi, lo);
    else n_pass++;
    run_op(OP_MULT, 32'h80000000, 32'h00000001, lat, bn);
    n_checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'h80000000) $display("FAIL mult_minneg_x1 got hi=%h lo=%h want FFFFFFFF 80000000", hi, lo);
    else n_pass++;
  endtask

  task automatic test_multu;
    int lat, bn;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bn);
    n_checks++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) $display("FAIL multu_max got hi=%h lo=%h want FFFFFFFE 00000001", hi, lo);
    else n_pass++;
    n_checks++;
    if (bn !== 33) $display("FAIL multu_busy_cycles got %0d want 33", bn);
    else n_pass++;
    n_checks++;
    if (lat !== 33) $display("FAIL multu_latency got %0d want 33", lat);
    else n_pass++;
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div;
    int lat, bn;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, lat, bn);
    n_checks++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) $display("FAIL div_signed got hi=%h lo=%h want FFFFFFFF FFFFFFFD", hi, lo);
    else n_pass++;
    n_checks++;
    if (lat !== 33 || bn !== 33) $display("FAIL div_latency got lat=%0d busy=%0d want 33 33", lat, bn);
    else n_pass++;
    run_op(OP_DIVU, 32'h00000007, 32'h00000000, lat, bn);
    n_checks++;
    if (lo !== 32'hFFFFFFFF || hi !== 32'h00000007) $display("FAIL divu_zero got hi=%h lo=%h want 00000007 FFFFFFFF", hi, lo);
    else n_pass++;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000000, lat, bn);
    n_checks++;
    if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF9) $display("FAIL div_zero_signed got hi=%h lo=%h want FFFFFFF9 FFFFFFFF", hi, lo);
    else n_pass++;
    run_op(OP_DIVU, 32'hFFFFFFF9, 32'h00000002, lat, bn);
    n_checks++;
    if (lo !== 32'h7FFFFFFC || hi !== 32'h00000001) $display("FAIL divu_big got hi=%h lo=%h want 00000001 7FFFFFFC", hi, lo);
    else n_pass++;
    run_op(OP_DIV, 32'h00000064, 32'hFFFFFFF9, lat, bn);
    n_checks++;
    if (lo !== 32'hFFFFFFF2 || hi !== 32'h00000002) $display("FAIL div_neg_divisor got hi=%h lo=%h want 00000002 FFFFFFF2", hi, lo);
    else n_pass++;
  endtask
`endif

  task automatic test_start_while_busy;
    int lat, bn;
    move_to(OP_MTHI, 32'h11111111);
    move_to(OP_MTLO, 32'h22222222);
    n_checks++;
    if (hi !== 32'h11111111 || lo !== 32'h22222222) $display("FAIL mt_write got hi=%h lo=%h want 11111111 22222222", hi, lo);
    else n_pass++;
    @(negedge clk);
    start = 1'b1; op = OP_MULT; rs_data = 32'h2; rt_data = 32'h3;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NOP;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; rs_data = 32'hAAAA5555;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NOP;
    n_checks++;
    if (hi !== 32'h11111111 || lo !== 32'h22222222 || busy !== 1'b1) $display("FAIL busy_hold got hi=%h lo=%h busy=%b want 11111111 22222222 1", hi, lo, busy);
    else n_pass++;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat !== 28) $display("FAIL ignored_start_latency got %0d want 28", lat);
    else n_pass++;
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h6) $display("FAIL ignored_mthi got hi=%h lo=%h want 00000000 00000006", hi, lo);
    else n_pass++;
  endtask

  task automatic test_mtlo_and_reset;
    int saw_done;
    move_to(OP_MTLO, 32'h12345678);
    n_checks++;
    if (lo !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) $display("FAIL mtlo got lo=%h busy=%b done=%b want 12345678 0 0", lo, busy, done);
    else n_pass++;
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; rs_data = 32'h9; rt_data = 32'h2;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NOP;
    repeat (9) @(posedge clk);
    #1;
`ifdef MDU_DIV_EN
    n_checks++;
    if (busy !== 1'b1) $display("FAIL divu_busy_before_reset got %b want 1", busy);
    else n_pass++;
`endif
    reset = 1'b1;
    #1;
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL async_reset got hi=%h lo=%h busy=%b done=%b want 0 0 0 0", hi, lo, busy, done);
    else n_pass++;
    @(negedge clk); reset = 1'b0;
    saw_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1;
    end
    n_checks++;
    if (saw_done !== 0 || hi !== 32'h0 || lo !== 32'h0) $display("FAIL op_discarded got activity=%0d hi=%h lo=%h want 0 0 0", saw_done, hi, lo);
    else n_pass++;
  endtask

`ifndef MDU_DIV_EN
  task automatic test_div_disabled;
    int seen;
    move_to(OP_MTHI, 32'h00000005);
    move_to(OP_MTLO, 32'h00000006);
    @(negedge clk);
    start = 1'b1; op = OP_DIV; rs_data = 32'h8; rt_data = 32'h2;
    #1;
    seen = stall ? 1 : 0;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NOP;
    repeat (40) begin
      if (busy || stall || done) seen = 1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL div_disabled_activity got %0d want 0", seen);
    else n_pass++;
    n_checks++;
    if (hi !== 32'h5 || lo !== 32'h6) $display("FAIL div_disabled_hilo got hi=%h lo=%h want 00000005 00000006", hi, lo);
    else n_pass++;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_mult();
    test_multu();
`ifdef MDU_DIV_EN
    test_div();
`endif
    test_start_while_busy();
    test_mtlo_and_reset();
`ifndef MDU_DIV_EN
    test_div_disabled();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
